sata_transport_cmd_tx: RTL and testbench

Host-side transport-layer transmitter for Register Host-to-Device FIS (type 0x27). Accepts a command descriptor from the command layer, serializes it into a 5-dword FIS on an AXI-Stream master toward the link layer, then waits for the link layer's R_OK/R_ERR result, retrying on error or timeout. It is the issuing end of the PIO exchange whose device response (PIO Setup FIS, 0x5F) the receive-side transport path detects.

---
 rtl/sata_transport_cmd_tx.sv | 142 ++++++++++++++
 tb/tb_sata_transport_cmd_tx.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_transport_cmd_tx.sv
// Register Host-to-Device FIS (0x27) transmitter. Latches a command descriptor,
// streams it as five dwords to the link layer and retries on R_ERR or status timeout.
module sata_transport_cmd_tx #(
  parameter int unsigned USER_W    = 8,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TMO_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_c,
  input  logic [3:0]        cmd_pm_port,
  input  logic [7:0]        cmd_command,
  input  logic [15:0]       cmd_features,
  input  logic [47:0]       cmd_lba,
  input  logic [7:0]        cmd_device,
  input  logic [15:0]       cmd_count,
  input  logic [7:0]        cmd_icc,
  input  logic [7:0]        cmd_control,
  output logic [31:0]       m_axis_link_tdata,
  output logic [USER_W-1:0] m_axis_link_tuser,
  output logic              m_axis_link_tvalid,
  input  logic              m_axis_link_tready,
  input  logic              link_tx_ok,
  input  logic              link_tx_err,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic              busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  localparam int unsigned     RetryW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  // Timeout fires on the edge at which the counter would reach all-ones,
  // i.e. after 2^TMO_W-1 cycles spent in the wait state.
  localparam logic [TMO_W-1:0]  TmoLast  = {TMO_W{1'b1}} - TMO_W'(1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [3:0][31:0]  frame_q, frame_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              fail;

  // Next-state: acceptance, beat sequencing and status/retry resolution
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    fail    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          frame_d[0] = {8'h27, cmd_c, 3'b000, cmd_pm_port, cmd_command, cmd_features[7:0]};
          frame_d[1] = {cmd_lba[7:0], cmd_lba[15:8], cmd_lba[23:16], cmd_device};
          frame_d[2] = {cmd_lba[31:24], cmd_lba[39:32], cmd_lba[47:40], cmd_features[15:8]};
          frame_d[3] = {cmd_count[7:0], cmd_count[15:8], cmd_icc, cmd_control};
          retry_d    = '0;
          idx_d      = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (m_axis_link_tready) begin
          if (idx_q == 3'd4) begin
            tmo_d   = '0;
            state_d = StWait;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StWait: begin
        tmo_d = tmo_q + TMO_W'(1);
        // An explicit error beats a simultaneous OK; OK beats a timeout.
        fail  = link_tx_err || (!link_tx_ok && (tmo_q == TmoLast));
        if (fail) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RetryW'(1);
            idx_d   = '0;
            state_d = StSend;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (link_tx_ok) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; async reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state so tvalid drops as soon as reset asserts
  always_comb begin
    cmd_ready          = (state_q == StIdle);
    busy               = (state_q != StIdle);
    m_axis_link_tvalid = (state_q == StSend);
    m_axis_link_tdata  = '0;
    m_axis_link_tuser  = '0;
    if (state_q == StSend) begin
      m_axis_link_tdata      = (idx_q == 3'd4) ? 32'h0 : frame_q[idx_q[1:0]];
      // {drop, err, keep[3:0], sop, eop}
      m_axis_link_tuser[7:0] = {2'b00, 4'hF, idx_q == 3'd0, idx_q == 3'd4};
    end
    cmd_done = done_q;
    cmd_err  = err_q;
  end

endmodule

// File: tb/tb_sata_transport_cmd_tx.sv
// Bench for sata_transport_cmd_tx: scoreboard of expected beats, one task per scenario.
module tb_sata_transport_cmd_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_c;
  logic [3:0]  cmd_pm_port;
  logic [7:0]  cmd_command, cmd_device, cmd_icc, cmd_control;
  logic [15:0] cmd_features, cmd_count;
  logic [47:0] cmd_lba;
  logic [31:0] m_axis_link_tdata;
  logic [7:0]  m_axis_link_tuser;
  logic        m_axis_link_tvalid, m_axis_link_tready;
  logic        link_tx_ok, link_tx_err, cmd_done, cmd_err, busy;

  always #5 clk = ~clk;

  sata_transport_cmd_tx #(.USER_W(8), .MAX_RETRY(3), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_c(cmd_c),
    .cmd_pm_port(cmd_pm_port), .cmd_command(cmd_command), .cmd_features(cmd_features),
    .cmd_lba(cmd_lba), .cmd_device(cmd_device), .cmd_count(cmd_count),
    .cmd_icc(cmd_icc), .cmd_control(cmd_control),
    .m_axis_link_tdata(m_axis_link_tdata), .m_axis_link_tuser(m_axis_link_tuser),
    .m_axis_link_tvalid(m_axis_link_tvalid), .m_axis_link_tready(m_axis_link_tready),
    .link_tx_ok(link_tx_ok), .link_tx_err(link_tx_err),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy)
  );

  typedef struct packed {
    logic        c;
    logic [3:0]  pm;
    logic [7:0]  command;
    logic [15:0] features;
    logic [47:0] lba;
    logic [7:0]  device;
    logic [15:0] count;
    logic [7:0]  icc;
    logic [7:0]  control;
  } cmd_t;

  logic [39:0] sb[$];  // {tdata, tuser}
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] usr(input logic sop, input logic eop);
    return {2'b00, 4'hF, sop, eop};
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.c        = 1'($urandom);
    c.pm       = 4'($urandom);
    c.command  = 8'($urandom);
    c.features = 16'($urandom);
    c.lba      = {16'($urandom), 32'($urandom)};
    c.device   = 8'($urandom);
    c.count    = 16'($urandom);
    c.icc      = 8'($urandom);
    c.control  = 8'($urandom);
    return c;
  endfunction

  task automatic push_frame(input cmd_t c);
    sb.push_back({8'h27, c.c, 3'b000, c.pm, c.command, c.features[7:0], usr(1'b1, 1'b0)});
    sb.push_back({c.lba[7:0], c.lba[15:8], c.lba[23:16], c.device, usr(1'b0, 1'b0)});
    sb.push_back({c.lba[31:24], c.lba[39:32], c.lba[47:40], c.features[15:8],
                  usr(1'b0, 1'b0)});
    sb.push_back({c.count[7:0], c.count[15:8], c.icc, c.control, usr(1'b0, 1'b0)});
    sb.push_back({32'h0, usr(1'b0, 1'b1)});
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_c = c.c; cmd_pm_port = c.pm; cmd_command = c.command; cmd_features = c.features;
    cmd_lba = c.lba; cmd_device = c.device; cmd_count = c.count; cmd_icc = c.icc;
    cmd_control = c.control;
    cmd_valid = 1'b1;
  endtask

  task automatic scramble_cmd();
    cmd_t c;
    c = rand_cmd();
    cmd_c = c.c; cmd_pm_port = c.pm; cmd_command = c.command; cmd_features = c.features;
    cmd_lba = c.lba; cmd_device = c.device; cmd_count = c.count; cmd_icc = c.icc;
    cmd_control = c.control;
  endtask

  // Hold cmd_valid until accepted, then garble the descriptor lines.
  task automatic accept();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_wait: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble_cmd();
  endtask

  // Consume nbeats handshakes, checking each against the scoreboard and stall stability.
  task automatic collect(input int nbeats, input bit toggle, output int first_cyc,
                         output int last_cyc);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [39:0] held = '0;
    logic [39:0] exp;
    first_cyc = -1;
    last_cyc  = -1;
    while (got < nbeats && cyc < nbeats * 3 + 10) begin
      m_axis_link_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (!m_axis_link_tvalid || {m_axis_link_tdata, m_axis_link_tuser} !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h required v=1 %h", m_axis_link_tvalid,
                   {m_axis_link_tdata, m_axis_link_tuser}, held);
        end
      end
      stalled = 1'b0;
      if (m_axis_link_tvalid) begin
        if (m_axis_link_tready) begin
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          got++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_extra: got %h required none",
                     {m_axis_link_tdata, m_axis_link_tuser});
          end else begin
            exp = sb.pop_front();
            if ({m_axis_link_tdata, m_axis_link_tuser} !== exp) begin
              errors++;
              $display("FAIL beat: got %h required %h",
                       {m_axis_link_tdata, m_axis_link_tuser}, exp);
            end
          end
        end else begin
          stalled = 1'b1;
          held = {m_axis_link_tdata, m_axis_link_tuser};
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (got != nbeats) begin
      errors++;
      $display("FAIL beat_count: got %0d beats required %0d", got, nbeats);
    end
  endtask

  // Pulse link status for one cycle; check the following cycle's outputs.
  task automatic status(input bit ok, input bit err, input bit exp_done, input bit exp_err);
    bit retry;
    retry = !(exp_done || exp_err);
    m_axis_link_tready = 1'b0;
    link_tx_ok = ok;
    link_tx_err = err;
    @(posedge clk); #1;
    link_tx_ok = 1'b0;
    link_tx_err = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_done, cmd_err, busy, m_axis_link_tvalid} !== {exp_done, exp_err, retry, retry}) begin
      errors++;
      $display("FAIL status: got done/err/busy/valid=%b%b%b%b required %b%b%b%b", cmd_done,
               cmd_err, busy, m_axis_link_tvalid, exp_done, exp_err, retry, retry);
    end
    if (retry && sb.size() > 0) begin
      checks++;
      if ({m_axis_link_tdata, m_axis_link_tuser} !== sb[0]) begin
        errors++;
        $display("FAIL retry_dw0: got %h required %h", {m_axis_link_tdata, m_axis_link_tuser},
                 sb[0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({cmd_ready, m_axis_link_tvalid, m_axis_link_tdata, m_axis_link_tuser, cmd_done, cmd_err,
         busy} !== {1'b1, 1'b0, 32'h0, 8'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h u=%h done=%b err=%b busy=%b",
               cmd_ready, m_axis_link_tvalid, m_axis_link_tdata, m_axis_link_tuser, cmd_done,
               cmd_err, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    cmd_t c;
    int f, l;
    c = '0;
    c.c = 1'b1; c.command = 8'h20; c.lba = 48'h0000_1234_5678; c.count = 16'd1;
    c.device = 8'h40;
    sb.push_back({32'h2780_2000, 8'h3E});
    sb.push_back({32'h7856_3440, 8'h3C});
    sb.push_back({32'h1200_0000, 8'h3C});
    sb.push_back({32'h0100_0000, 8'h3C});
    sb.push_back({32'h0000_0000, 8'h3D});
    drive_cmd(c);
    accept();
    collect(5, 1'b0, f, l);
    checks++;
    if (f != 0 || l != 4) begin
      errors++;
      $display("FAIL basic_timing: first=%0d last=%0d required 0 and 4", f, l);
    end
    status(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (cmd_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: cmd_done=%b required 0", cmd_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    cmd_t c;
    int f, l;
    c = rand_cmd();
    push_frame(c);
    drive_cmd(c);
    accept();
    collect(5, 1'b1, f, l);
    checks++;
    if (l != 8) begin
      errors++;
      $display("FAIL stall_last: last beat cycle=%0d required 8", l);
    end
    status(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_retry_ok();
    cmd_t c;
    int f, l;
    c = rand_cmd();
    push_frame(c);
    drive_cmd(c);
    accept();
    for (int k = 0; k < 3; k++) begin
      collect(5, 1'b0, f, l);
      if (k < 2) begin
        push_frame(c);
        status(1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        status(1'b1, 1'b0, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic test_retry_fail();
    cmd_t c;
    int f, l;
    c = rand_cmd();
    push_frame(c);
    drive_cmd(c);
    accept();
    for (int k = 0; k < 4; k++) begin
      collect(5, 1'b0, f, l);
      if (k < 3) begin
        push_frame(c);
        status(1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        status(1'b0, 1'b1, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic test_timeout();
    cmd_t c;
    int f, l;
    int n = 0;
    c = rand_cmd();
    push_frame(c);
    drive_cmd(c);
    accept();
    collect(5, 1'b0, f, l);
    push_frame(c);
    m_axis_link_tready = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_busy: busy=%b required 1", busy);
    end
    @(negedge clk);
    while (!m_axis_link_tvalid && n < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL timeout_len: wait cycles=%0d required 15", n);
    end
    @(posedge clk); #1;
    collect(5, 1'b0, f, l);
    push_frame(c);
    status(1'b1, 1'b1, 1'b0, 1'b0);
    collect(5, 1'b0, f, l);
    status(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_idle_status();
    link_tx_ok = 1'b1;
    link_tx_err = 1'b1;
    @(posedge clk); #1;
    link_tx_ok = 1'b0;
    link_tx_err = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_done, cmd_err, busy, m_axis_link_tvalid} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_status: done/err/busy/valid=%b%b%b%b required 0000", cmd_done,
               cmd_err, busy, m_axis_link_tvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    int f, l;
    bit seen = 1'b0;
    c = rand_cmd();
    push_frame(c);
    drive_cmd(c);
    accept();
    collect(2, 1'b0, f, l);
    m_axis_link_tready = 1'b0;
    @(negedge clk);
    checks++;
    if (!m_axis_link_tvalid || {m_axis_link_tdata, m_axis_link_tuser} !== sb[0]) begin
      errors++;
      $display("FAIL beat2_present: got v=%b %h required v=1 %h", m_axis_link_tvalid,
               {m_axis_link_tdata, m_axis_link_tuser}, sb[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_link_tvalid, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_async: valid/busy/ready=%b%b%b required 001", m_axis_link_tvalid,
               busy, cmd_ready);
    end
    #1 rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (cmd_done || cmd_err || m_axis_link_tvalid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_quiet: spurious done/err/valid got 1 required 0");
    end
    c = rand_cmd();
    push_frame(c);
    drive_cmd(c);
    accept();
    collect(5, 1'b0, f, l);
    checks++;
    if (f != 0) begin
      errors++;
      $display("FAIL restart_first: first beat cycle=%0d required 0", f);
    end
    status(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    cmd_t a, b;
    int f, l;
    a = rand_cmd();
    b = rand_cmd();
    push_frame(a);
    drive_cmd(a);
    accept();
    collect(5, 1'b0, f, l);
    push_frame(b);
    drive_cmd(b);  // held through WAIT_STAT, taken in the done cycle
    status(1'b1, 1'b0, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    scramble_cmd();
    checks++;
    if (m_axis_link_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: tvalid=%b required 1", m_axis_link_tvalid);
    end
    collect(5, 1'b0, f, l);
    checks++;
    if (f != 0) begin
      errors++;
      $display("FAIL b2b_first: first beat cycle=%0d required 0", f);
    end
    status(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    cmd_valid = 1'b0;
    m_axis_link_tready = 1'b0;
    link_tx_ok = 1'b0;
    link_tx_err = 1'b0;
    scramble_cmd();
    test_reset();
    test_basic();
    test_stall();
    test_retry_ok();
    test_retry_fail();
    test_timeout();
    test_ignore_idle_status();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d beats left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
